// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared enums and channel transmit order for the NeoPixel strip controller.
package neopixel_pkg;
    typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2} color_e;
    typedef enum logic [2:0] {IDLE, START, BIT_HIGH, BIT_LOW, LATCH} ctrl_state_e;
    // WS2812 parts expect green first, then red, then blue
    localparam color_e GRB_ORDER [3] = '{GREEN, RED, BLUE};
endpackage

// File: rtl/neopixel_strip_ctrl_if.sv
// neopixel_strip_ctrl_if: load/send handshake and serial output of the strip controller.
interface neopixel_strip_ctrl_if #(
    parameter int PIX_W   = 3,
    parameter int COLOR_W = 8
);
    logic [PIX_W-1:0]   pixel_index;
    logic [1:0]         color_index;
    logic [COLOR_W-1:0] color_level;
    logic               load_color;
    logic               send_it;
    logic               neo_data;
    logic               ready_to_load;
    logic               ready_to_send;
    logic               load_error;
    modport master (
        output pixel_index, color_index, color_level, load_color, send_it,
        input  neo_data, ready_to_load, ready_to_send, load_error
    );
    modport slave (
        input  pixel_index, color_index, color_level, load_color, send_it,
        output neo_data, ready_to_load, ready_to_send, load_error
    );
endinterface

// File: rtl/neopixel_bit_encoder.sv
// neopixel_bit_encoder: shapes one data bit into a T_BIT-cycle high/low one-wire pulse.
module neopixel_bit_encoder #(
    parameter int T_BIT = 63,
    parameter int T0H   = 20,
    parameter int T1H   = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic wave,
    output logic high_done,
    output logic bit_done
);
    localparam int CW = $clog2(T_BIT);
    logic [CW-1:0] cnt;
    logic [CW-1:0] high_len;
    logic          bit_q;
    logic          busy;
    assign high_len  = bit_q ? CW'(T1H) : CW'(T0H);
    assign high_done = busy && cnt == high_len - 1'b1;
    assign bit_done  = busy && cnt == CW'(T_BIT - 1);
    // a start on the bit_done edge chains the next bit with no gap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            bit_q <= 1'b0;
            busy  <= 1'b0;
            wave  <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            bit_q <= bit_val;
            busy  <= 1'b1;
            wave  <= 1'b1;
        end else if (busy) begin
            cnt  <= bit_done ? '0 : cnt + 1'b1;
            busy <= !bit_done;
            wave <= wave && !high_done;
        end
    end
endmodule

// File: rtl/neopixel_strip_ctrl.sv
// neopixel_strip_ctrl: frame buffer plus serialiser driving a WS2812-class strip,
// pixel 0 first, channels G/R/B MSB first, followed by a latch interval.
module neopixel_strip_ctrl
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int COLOR_W    = 8,
    parameter int T_BIT      = 63,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int T_LATCH    = 2500
) (
    input logic clock,
    input logic reset,
    neopixel_strip_ctrl_if.slave bus
);
    localparam int PIX_W   = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1;
    localparam int PX_BITS = 3 * COLOR_W;
    localparam int BIT_W   = $clog2(PX_BITS);
    localparam int LAT_W   = $clog2(T_LATCH + 1);

    ctrl_state_e        state, state_nxt;
    logic [COLOR_W-1:0] frame_buf [NUM_PIXELS][3];
    logic [PX_BITS-1:0] shift_reg, pix_word, word_nxt;
    logic [PIX_W-1:0]   pix, pix_nxt;
    logic [BIT_W-1:0]   bit_idx;
    logic [LAT_W-1:0]   latch_cnt;
    logic               load_ok, first, pix_end, last_bit, enc_start;
    logic               wave, high_done, bit_done;

    assign bus.ready_to_load = state == IDLE || state == LATCH;
    assign bus.ready_to_send = state == IDLE;
    assign bus.neo_data      = wave;
    assign load_ok   = bus.load_color && bus.ready_to_load && bus.color_index != 2'd3 &&
                       {1'b0, bus.pixel_index} < (PIX_W + 1)'(NUM_PIXELS);
    assign first     = state == START;
    assign pix_end   = bit_idx == BIT_W'(PX_BITS - 1);
    assign last_bit  = pix_end && pix == PIX_W'(NUM_PIXELS - 1);
    assign enc_start = first || (state == BIT_LOW && bit_done && !last_bit);
    assign pix_nxt   = first ? '0 : pix_end ? pix + 1'b1 : pix;

    // a new pixel is fetched whole, in transmit order, at each pixel boundary
    always_comb begin
        pix_word = '0;
        for (int c = 0; c < 3; c++)
            pix_word[(2 - c) * COLOR_W +: COLOR_W] = frame_buf[pix_nxt][GRB_ORDER[c]];
        word_nxt = (first || pix_end) ? pix_word : shift_reg;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = bus.send_it ? START : IDLE;
            START:    state_nxt = BIT_HIGH;
            BIT_HIGH: state_nxt = high_done ? BIT_LOW : BIT_HIGH;
            BIT_LOW:  state_nxt = bit_done ? (last_bit ? LATCH : BIT_HIGH) : BIT_LOW;
            LATCH:    state_nxt = latch_cnt == LAT_W'(T_LATCH - 1) ? IDLE : LATCH;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shift_reg      <= '0;
            pix            <= '0;
            bit_idx        <= '0;
            latch_cnt      <= '0;
            bus.load_error <= 1'b0;
            for (int p = 0; p < NUM_PIXELS; p++)
                for (int c = 0; c < 3; c++)
                    frame_buf[p][c] <= '0;
        end else begin
            state          <= state_nxt;
            bus.load_error <= bus.load_color && !load_ok;
            latch_cnt      <= state == LATCH ? latch_cnt + 1'b1 : '0;
            if (load_ok)
                frame_buf[bus.pixel_index][bus.color_index] <= bus.color_level;
            if (enc_start) begin
                shift_reg <= word_nxt << 1;
                pix       <= pix_nxt;
                bit_idx   <= (first || pix_end) ? '0 : bit_idx + 1'b1;
            end
        end
    end

    neopixel_bit_encoder #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_enc (
        .clock     (clock),
        .reset     (reset),
        .start     (enc_start),
        .bit_val   (word_nxt[PX_BITS-1]),
        .wave      (wave),
        .high_done (high_done),
        .bit_done  (bit_done)
    );
endmodule

// File: doc/neopixel_strip_ctrl.md
Name: neopixel_strip_ctrl

Overview:
Parametrised NeoPixel (WS2812-class) strip controller. Holds a per-pixel RGB frame buffer written one colour at a time by the `load_color` interface. On `send_it` it serialises the whole frame onto `neo_data` with programmable one-wire bit timing, then holds the line low for a latch interval. It generalises the fixed 8-pixel controller to any pixel count, colour depth and clock rate, and adds rejection of illegal loads and an error flag.

Parameters:
NUM_PIXELS, 8, pixels in strip (>=1); PIX_W = $clog2(NUM_PIXELS) derived (min 1)
COLOR_W, 8, bits per colour channel
T_BIT, 63, clock cycles per data bit (1.25 us at 50 MHz)
T0H, 20, high cycles for a 0 bit
T1H, 40, high cycles for a 1 bit; require 0 < T0H < T1H < T_BIT
T_LATCH, 2500, low cycles after last bit (50 us at 50 MHz)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
pixel_index  input  PIX_W  pixel to write
color_index  input  2  0=red, 1=green, 2=blue, 3=illegal
color_level  input  COLOR_W  channel intensity
load_color  input  1  write strobe, sampled at posedge
send_it  input  1  start frame transmission, sampled at posedge
neo_data  output  1  serial data to strip, registered
ready_to_load  output  1  loads accepted this cycle
ready_to_send  output  1  send_it accepted this cycle
load_error  output  1  one-cycle pulse: last load rejected

Behaviour:
- Reset (asynchronous, active-high):
  - Buffer cleared to zero; state IDLE.
  - neo_data=0, ready_to_load=1, ready_to_send=1, load_error=0.
  - Reset mid-frame: neo_data drops to 0 immediately; the frame is abandoned.
- States:
  - IDLE: ready_to_load=1, ready_to_send=1.
  - START: one cycle; fetches pixel 0 into the shift register.
  - BIT_HIGH / BIT_LOW: serialise the frame.
  - LATCH: ready_to_load=1, ready_to_send=0.
- Load:
  - Legal load: load_color=1 while ready_to_load=1, pixel_index<NUM_PIXELS, color_index<3. Writes buffer[pixel_index][color_index]=color_level at that edge.
  - Any other load_color=1 (out of range, colour 3, or not ready): no write; load_error=1 for the following cycle.
- Send:
  - send_it=1 in IDLE at edge k → START. neo_data rises at edge k+1.
  - send_it is ignored in all other states; no error is flagged.
- Same-cycle load_color and send_it in IDLE: the write happens first, and the frame transmits the new value.
- Frame order: pixel 0 first. Per pixel the channels go G, R, B, each MSB first. Total bits N = NUM_PIXELS*3*COLOR_W.
- Bit waveform:
  - neo_data=1 for T1H cycles if the bit is 1, T0H cycles if 0.
  - Then neo_data=0 for the remainder of T_BIT.
  - Bits are back-to-back, with no gap between pixels.
- After the last bit: LATCH with neo_data=0 for T_LATCH cycles, then IDLE.
  - Total busy time from send_it edge to ready_to_send=1: 1 + N*T_BIT + T_LATCH cycles.
- Loads during LATCH update the buffer for the next frame only.
- Counters:
  - Bit-cycle counter is $clog2(T_BIT) wide.
  - Latch counter is $clog2(T_LATCH+1) wide.
  - Bit and pixel indices wrap only at frame end; no counter overflow is permitted.

Decomposition:
- Package neopixel_pkg:
  - color_e enum: RED=0, GREEN=1, BLUE=2.
  - ctrl_state_e enum: IDLE, START, BIT_HIGH, BIT_LOW, LATCH.
  - Constant GRB transmit-order array.
- Sub-module neopixel_bit_encoder:
  - Inputs: bit value and start.
  - Outputs: waveform and bit_done.
  - Owns the T_BIT/T0H/T1H counter.
- Top module owns the buffer, shift register, pixel/channel indices and FSM.

Test Plan:
Bench parameters: NUM_PIXELS=2, COLOR_W=8, T_BIT=6, T0H=2, T1H=4, T_LATCH=10.
1. Reset assert → neo_data=0, ready_to_load=1, ready_to_send=1, load_error=0. Sending the zeroed buffer → 48 bits each 2 high/4 low, then 10 low cycles; ready_to_send=1 exactly 299 cycles after the send_it edge.
2. Load pixel0 G=0x80, R=0x01, B=0xFF, then send → first bit 4 high/2 low; next 7 bits 2 high/4 low; R ends with a 4-high bit; B is 8 long-high bits; pixel 1 is all short bits.
3. load_color with pixel_index=2, then with color_index=3 → load_error pulses one cycle each; subsequent frame unchanged.
4. During BIT_HIGH: send_it=1 and load_color → send ignored, load_error=1, frame unchanged. Load during LATCH (pixel1 B=0x0F) → no error; appears only in the next frame.
5. In IDLE, load pixel0 G=0xFF and send_it in the same cycle → first transmitted byte is 0xFF.
6. Assert reset at frame bit 20 → neo_data=0 immediately; ready flags=1; next send transmits all zeros.
